fifo_rd_word_packer: RTL

Read-domain consumer that sits directly downstream of the team's asynchronous FIFO. It pops narrow entries from the FIFO read port and packs LANES consecutive entries into one wide word, LSB lane first. It presents each word on a valid/ready output. An idle timeout flushes a partially filled word, with a keep mask marking the valid lanes.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_rd_word_packer_if.sv | 28 ++
 rtl/fifo_idle_timer.sv | 41 ++++
 rtl/fifo_rd_word_packer.sv | 102 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side word packers (read and write side).
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int LANES      = 4;
  localparam int LANE_CNT_W = $clog2(LANES) + 1;
  localparam int MAX_LANES  = 32;

  typedef logic [DATA_WIDTH-1:0] lane_t;

  // Mask with the low `count` bits set; callers slice it to their lane count.
  function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned count);
    if (count >= MAX_LANES) return '1;
    return (MAX_LANES'(1) << count) - MAX_LANES'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_word_packer_if.sv
// FIFO read port plus packed-word valid/ready output of the read-side packer.
interface fifo_rd_word_packer_if
  import fifo_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int lanes      = LANES
);

  logic                        fifo_empty;
  logic                        fifo_rd_en;
  logic [data_width-1:0]       fifo_data;
  logic [data_width*lanes-1:0] m_data;
  logic [lanes-1:0]            m_keep;
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_last;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_data, m_keep, m_valid, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_data, m_keep, m_valid, m_last
  );

endinterface

// File: rtl/fifo_idle_timer.sv
// Saturating idle counter that requests a flush after `timeout` idle cycles.
module fifo_idle_timer
  import fifo_pkg::*;
#(
  parameter int timeout = 16
) (
  input  logic rd_clk,
  input  logic rd_rst_n,
  input  logic en,
  input  logic clr,
  output logic flush_req
);

  localparam int CNT_W = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(timeout);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Kept apart from the counter update so clr (which depends on flush_req) forms no loop.
  assign flush_req = (timeout != 0) && en && (cnt_q == TIMEOUT_C);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TIMEOUT_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; combinational logic uses blocking.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_rd_word_packer.sv
// Pops narrow FIFO entries and packs `lanes` of them, LSB lane first, into one
// wide valid/ready word; an idle timeout flushes a partial word with m_last=1.
module fifo_rd_word_packer
  import fifo_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int lanes      = LANES,
  parameter int timeout    = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  fifo_rd_word_packer_if.master bus
);

  localparam int CNT_W = $clog2(lanes) + 1;
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(lanes);

  typedef logic [lanes-1:0][data_width-1:0] word_t;

  logic [CNT_W-1:0]     lane_cnt_q, lane_cnt_d, cnt_next;
  logic                 pend_q, pend_d;
  word_t                lane_q, lane_d, word_c, m_data_q, m_data_d;
  logic [lanes-1:0]     keep_c, m_keep_q, m_keep_d;
  logic [MAX_LANES-1:0] keep_full;
  logic                 m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic                 full, out_free, load, rd_en;
  logic                 flush_req, timer_en, timer_clr;

  // Idle time only counts for a partial word with nothing in flight.
  assign timer_en = (lane_cnt_q != '0) && (lane_cnt_q < LANES_C) && !pend_q;

  fifo_idle_timer #(.timeout(timeout)) u_idle_timer (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .en        (timer_en),
    .clr       (timer_clr),
    .flush_req (flush_req)
  );

  always_comb begin
    cnt_next  = lane_cnt_q + CNT_W'(pend_q);
    full      = (cnt_next == LANES_C);
    out_free  = !m_valid_q || bus.m_ready;
    load      = (full || flush_req) && out_free;
    timer_clr = pend_q || load;
    // A word leaving this cycle frees all its lane slots, so the next pop can overlap.
    rd_en     = !bus.fifo_empty && !flush_req && (load || (cnt_next < LANES_C));

    lane_d = lane_q;
    if (pend_q) lane_d[lane_cnt_q[CNT_W-2:0]] = bus.fifo_data;

    keep_full = keep_mask(32'(cnt_next));
    keep_c    = keep_full[lanes-1:0];
    for (int k = 0; k < lanes; k++) begin
      word_c[k] = keep_c[k] ? lane_d[k] : '0;
    end

    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q && !bus.m_ready;
    lane_cnt_d = cnt_next;
    pend_d     = rd_en;
    if (load) begin
      m_data_d   = word_c;
      m_keep_d   = keep_c;
      m_last_d   = flush_req;
      m_valid_d  = 1'b1;
      lane_cnt_d = '0;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      lane_cnt_q <= '0;
      pend_q     <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      pend_q     <= pend_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
    end
  end

  // NOTE: lane storage is deliberately not reset; stale lanes are masked by keep on load.
  always_ff @(posedge rd_clk) begin
    lane_q <= lane_d;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_data     = m_data_q;
  assign bus.m_keep     = m_keep_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;

endmodule
